// File: rtl/imm_gen_pkg.sv
// Shared decode constants, format codes and buffer occupancy states for the immediate generator.
package imm_gen_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  // Width-independent part of a buffered entry; imm and tag widths are set by the top.
  typedef struct packed {
    logic [2:0] fmt;
    logic       illegal;
  } dec_info_t;

  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } cnt_state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational instruction -> {imm, fmt, illegal}; zero latency, no flow control.
// IMM_SHAMT_EN: I-type shifts emit a zero-extended shamt instead of the raw 12-bit immediate.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output dec_info_t       info
);

  logic [6:0]  opcode;
  logic [31:0] imm32;

  assign opcode = inst[6:0];

  always_comb begin
    imm32 = '0;
    info  = '{fmt: FMT_R, illegal: 1'b0};
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        imm32    = {{20{inst[31]}}, inst[31:20]};
        info.fmt = FMT_I;
      end
      OP_STORE: begin
        imm32    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        info.fmt = FMT_S;
      end
      OP_BRANCH: begin
        imm32    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        info.fmt = FMT_B;
      end
      OP_LUI, OP_AUIPC: begin
        imm32    = {inst[31:12], 12'b0};
        info.fmt = FMT_U;
      end
      OP_JAL: begin
        imm32    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        info.fmt = FMT_J;
      end
      OP_REG, OP_REG32: ;
      default: info.illegal = 1'b1;
    endcase

    // Every 32-bit immediate above is already sign-correct; widening keeps inst[31] replicated.
    imm = XLEN'($signed(imm32));
`ifdef IMM_SHAMT_EN
    // slli/srli/srai: funct3 = x01; the funct7 bits above the shamt are dropped.
    if (opcode == OP_IMM && inst[13:12] == 2'b01) begin
      imm = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
    end
`endif
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with 2-entry skid buffer; 1 cycle accept-to-valid latency.
// Backpressure: in_ready_o drops only when both entries are held; outputs hold while out_ready_i=0.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      inst_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [2:0]       fmt_o,
  output logic             illegal_o,
  output logic [TAG_W-1:0] tag_o
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    dec_info_t        info;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  dec_info_t       dec_info;
  entry_t          in_ent;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst (inst_i),
    .imm  (dec_imm),
    .info (dec_info)
  );

  assign in_ent = '{imm: dec_imm, info: dec_info, tag: tag_i};

  cnt_state_e state_q, state_d;
  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  logic       push, pop;

  // Handshake flags come straight from the state register, so ready/valid are glitch-free.
  assign in_ready_o  = (state_q != CNT_FULL);
  assign out_valid_o = (state_q != CNT_EMPTY);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush_i) begin
      state_d = CNT_EMPTY;
    end else begin
      case (state_q)
        CNT_EMPTY: begin
          if (push) begin
            head_d  = in_ent;
            state_d = CNT_ONE;
          end
        end
        CNT_ONE: begin
          case ({push, pop})
            2'b11: head_d = in_ent;
            2'b10: begin
              tail_d  = in_ent;
              state_d = CNT_FULL;
            end
            2'b01: state_d = CNT_EMPTY;
            default: ;
          endcase
        end
        CNT_FULL: begin
          if (pop) begin
            head_d  = tail_q;
            state_d = CNT_ONE;
          end
        end
        default: state_d = CNT_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= CNT_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign imm_o     = head_q.imm;
  assign fmt_o     = head_q.info.fmt;
  assign illegal_o = head_q.info.illegal;
  assign tag_o     = head_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe (XLEN=32): spec vectors, handshake corner cases, random scoreboard.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [7:0]  tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] imm;
  logic [2:0]  fmt;
  logic        illegal;
  logic [7:0]  tag_out;

  int total = 0;
  int bad   = 0;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .inst_i      (inst),
    .tag_i       (tag),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .imm_o       (imm),
    .fmt_o       (fmt),
    .illegal_o   (illegal),
    .tag_o       (tag_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [7:0]  tag;
  } exp_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Reference decoder built from the field placement rules using shifts and masks.
  function automatic exp_t ref_dec(input logic [31:0] in_inst, input logic [7:0] in_tag);
    exp_t        e;
    int          s;
    int unsigned u;
    int unsigned f3;
    s  = int'(in_inst);
    u  = in_inst;
    f3 = (u >> 12) & 7;
    e.imm = 0;
    e.fmt = 0;
    e.ill = 0;
    e.tag = in_tag;
    case (u & 32'h7f)
      32'h13, 32'h03, 32'h67, 32'h73: begin
        e.fmt = 1;
        e.imm = 32'(s >>> 20);
`ifdef IMM_SHAMT_EN
        if ((u & 32'h7f) == 32'h13 && (f3 == 1 || f3 == 5)) e.imm = (u >> 20) & 31;
`endif
      end
      32'h23: begin
        e.fmt = 2;
        e.imm = 32'((s >>> 25) << 5) | ((u >> 7) & 31);
      end
      32'h63: begin
        e.fmt = 3;
        e.imm = 32'((s >>> 31) << 12) | (((u >> 7) & 1) << 11) |
                (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1);
      end
      32'h37, 32'h17: begin
        e.fmt = 4;
        e.imm = u & 32'hffff_f000;
      end
      32'h6f: begin
        e.fmt = 5;
        e.imm = 32'((s >>> 31) << 20) | (((u >> 12) & 255) << 12) |
                (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1);
      end
      32'h33, 32'h3b: ;
      default: e.ill = 1;
    endcase
    if (f3 > 7) e.ill = 1'bx;
    return e;
  endfunction

  task automatic chk_head(input string nm, input exp_t e);
    chk({nm, ".valid"}, 64'(out_valid), 64'd1);
    chk({nm, ".imm"}, 64'(imm), 64'(e.imm));
    chk({nm, ".fmt"}, 64'(fmt), 64'(e.fmt));
    chk({nm, ".ill"}, 64'(illegal), 64'(e.ill));
    chk({nm, ".tag"}, 64'(tag_out), 64'(e.tag));
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [7:0] t);
    in_valid = v;
    inst     = i;
    tag      = t;
  endtask

  vec_t        vt[7];
  exp_t        ea, eb, q[$];
  logic [31:0] rnd;
  logic        pend;
  int unsigned ops[14] = '{32'h13, 32'h03, 32'h67, 32'h73, 32'h23, 32'h63, 32'h37,
                           32'h17, 32'h6f, 32'h33, 32'h3b, 32'h7f, 32'h00, 32'h0b};

  initial begin
    vt[0] = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0};
    vt[1] = '{32'hFE20AE23, 32'hFFFFFFFC, 3'd2, 1'b0};
    vt[2] = '{32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 1'b0};
    vt[3] = '{32'h123452B7, 32'h12345000, 3'd4, 1'b0};
    vt[4] = '{32'h001000EF, 32'h00000800, 3'd5, 1'b0};
    vt[5] = '{32'h0000007F, 32'h00000000, 3'd0, 1'b1};
`ifdef IMM_SHAMT_EN
    vt[6] = '{32'h4030D093, 32'h00000003, 3'd1, 1'b0};
`else
    vt[6] = '{32'h4030D093, 32'h00000403, 3'd1, 1'b0};
`endif

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 8'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.ready", 64'(in_ready), 64'd1);
    chk("rst.imm", 64'(imm), 64'd0);
    chk("rst.fmt", 64'(fmt), 64'd0);
    chk("rst.ill", 64'(illegal), 64'd0);
    chk("rst.tag", 64'(tag_out), 64'd0);

    // Spec vectors: one entry each, checked the cycle after acceptance.
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, vt[i].inst, 8'(8'h20 + i));
      @(negedge clk);
      drive(1'b0, 32'h0, 8'h0);
      chk_head($sformatf("vec%0d", i), '{vt[i].imm, vt[i].fmt, vt[i].ill, 8'(8'h20 + i)});
      @(negedge clk);
      chk($sformatf("vec%0d.drain", i), 64'(out_valid), 64'd0);
    end

    // Backpressure: fill both entries, hold, then drain in order.
    out_ready = 1'b0;
    ea = ref_dec(32'hFFF00093, 8'hA1);
    eb = ref_dec(32'h123452B7, 8'hB2);
    drive(1'b1, 32'hFFF00093, 8'hA1);
    @(negedge clk);
    chk("bp.ready_one", 64'(in_ready), 64'd1);
    drive(1'b1, 32'h123452B7, 8'hB2);
    @(negedge clk);
    drive(1'b0, 32'h0, 8'h0);
    chk("bp.ready_full", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk_head($sformatf("bp.hold%0d", i), ea);
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk_head("bp.a", ea);
    @(negedge clk);
    chk_head("bp.b", eb);
    chk("bp.ready_after", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("bp.empty", 64'(out_valid), 64'd0);

    // Flush from FULL with a concurrent input that must be dropped.
    out_ready = 1'b0;
    drive(1'b1, 32'hFE20AE23, 8'h01);
    @(negedge clk);
    drive(1'b1, 32'hFE000CE3, 8'h02);
    @(negedge clk);
    chk("fl.full", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    flush = 1'b1;
    drive(1'b1, 32'h001000EF, 8'h03);
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'h0, 8'h0);
    chk("fl.valid", 64'(out_valid), 64'd0);
    chk("fl.ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("fl.c_dropped", 64'(out_valid), 64'd0);

    // Flush from ONE with a concurrent accept (in_ready high in that cycle).
    drive(1'b1, 32'hFFF00093, 8'h04);
    @(negedge clk);
    flush = 1'b1;
    drive(1'b1, 32'h123452B7, 8'h05);
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'h0, 8'h0);
    chk("fl1.valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("fl1.dropped", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-stream: takes effect between clock edges.
    out_ready = 1'b0;
    drive(1'b1, 32'hFE20AE23, 8'h77);
    @(negedge clk);
    drive(1'b1, 32'hFE000CE3, 8'h78);
    @(negedge clk);
    drive(1'b0, 32'h0, 8'h0);
    chk("ar.pre_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar.valid", 64'(out_valid), 64'd0);
    chk("ar.ready", 64'(in_ready), 64'd1);
    chk("ar.imm", 64'(imm), 64'd0);
    chk("ar.fmt", 64'(fmt), 64'd0);
    chk("ar.tag", 64'(tag_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("ar.after", 64'(out_valid), 64'd0);

    // Random traffic against a queue scoreboard of capacity 2.
    pend = 1'b0;
    q.delete();
    for (int c = 0; c < 600; c++) begin
      chk($sformatf("rnd%0d.valid", c), 64'(out_valid), 64'(q.size() > 0));
      chk($sformatf("rnd%0d.ready", c), 64'(in_ready), 64'(q.size() < 2));
      if (q.size() > 0) begin
        chk($sformatf("rnd%0d.imm", c), 64'(imm), 64'(q[0].imm));
        chk($sformatf("rnd%0d.fmt", c), 64'(fmt), 64'(q[0].fmt));
        chk($sformatf("rnd%0d.ill", c), 64'(illegal), 64'(q[0].ill));
        chk($sformatf("rnd%0d.tag", c), 64'(tag_out), 64'(q[0].tag));
      end
      if (!pend) begin
        rnd = $urandom;
        drive(($urandom_range(0, 2) != 0),
              {rnd[31:7], 7'(ops[$urandom_range(0, 13)])}, 8'($urandom));
        pend = in_valid;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      if (in_valid && q.size() < 2) begin
        pend = 1'b0;
        ea   = ref_dec(inst, tag);
      end
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (in_valid && !pend) q.push_back(ea);
      end
      if (!pend) in_valid = in_valid;
      @(negedge clk);
      if (!pend) drive(1'b0, 32'h0, 8'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
